// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command sequencer in front of the combinational alu_flags block. Commands
// arrive over valid/ready. Their fields are registered and drive the ALU for
// exactly one EXEC cycle. The result and status are captured into a response
// register that is held under backpressure. An 8-bit accumulator supports
// chained operations. A sticky status register ORs every captured status, and
// a counter tallies completed operations.
module alu_cmd_sequencer #(
    parameter logic [7:0] ACC_INIT = 8'h00,
    parameter int         COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,

    // command channel
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [7:0]         cmd_op1,
    input  logic [7:0]         cmd_op2,
    input  logic               cmd_use_acc,
    input  logic               cmd_wb,
    input  logic               acc_clear,
    input  logic               sticky_clear,

    // ALU interface
    output logic [7:0]         alu_operand1,
    output logic [7:0]         alu_operand2,
    output logic [3:0]         alu_opcode,
    output logic               alu_enable,
    input  logic [15:0]        alu_result,
    input  logic [3:0]         alu_status,

    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_result,
    output logic [3:0]         rsp_status,

    // architectural state
    output logic [7:0]         acc_value,
    output logic [3:0]         sticky_status,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   wb_q;

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    assign accept = cmd_valid & cmd_ready;

    // State register. The FSM has only one real sequential process.
    // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake/enable decode. EXEC always lasts one cycle.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        alu_enable = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = EXEC;
            end
            EXEC: begin
                alu_enable = 1'b1;
                state_nxt  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    cmd_ready = 1'b1;
                    state_nxt = cmd_valid ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the command fields on accept. Operand 1 takes the accumulator
    // value of this cycle, before any coincident acc_clear takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_operand1 <= 8'h00;
            alu_operand2 <= 8'h00;
            alu_opcode   <= 4'h0;
            wb_q         <= 1'b0;
        end else if (accept) begin
            alu_operand1 <= cmd_use_acc ? acc_value : cmd_op1;
            alu_operand2 <= cmd_op2;
            alu_opcode   <= cmd_opcode;
            wb_q         <= cmd_wb;
        end
    end

    // Capture the ALU response at the end of EXEC. Hold it until the next EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= 16'h0000;
            rsp_status <= 4'h0;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_status <= alu_status;
        end
    end

    // Accumulator. acc_clear takes priority over an EXEC writeback of result[7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_value <= ACC_INIT;
        end else if (acc_clear) begin
            acc_value <= ACC_INIT;
        end else if (state == EXEC && wb_q) begin
            acc_value <= alu_result[7:0];
        end
    end

    // Sticky status. The current operation's status survives a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_status <= 4'h0;
        end else if (state == EXEC) begin
            sticky_status <= (sticky_clear ? 4'h0 : sticky_status) | alu_status;
        end else if (sticky_clear) begin
            sticky_status <= 4'h0;
        end
    end

    // Completed-operation counter. It wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (state == EXEC) begin
            op_count <= op_count + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer. A small behavioural alu_flags
// stand-in supplies the results. Inputs are driven at the falling edge, and
// outputs are sampled at the falling edge or shortly after it.
module tb_alu_cmd_sequencer;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_INC = 4'b1101;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_op1;
    logic [7:0]  cmd_op2;
    logic        cmd_use_acc;
    logic        cmd_wb;
    logic        acc_clear;
    logic        sticky_clear;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [3:0]  alu_opcode;
    logic        alu_enable;
    logic [15:0] alu_result;
    logic [3:0]  alu_status;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_status;
    logic [7:0]  acc_value;
    logic [3:0]  sticky_status;
    logic [7:0]  op_count;

    int checks;
    int failures;

    alu_cmd_sequencer #(.ACC_INIT(8'h00), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_use_acc(cmd_use_acc),
        .cmd_wb(cmd_wb), .acc_clear(acc_clear), .sticky_clear(sticky_clear),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_status(rsp_status),
        .acc_value(acc_value), .sticky_status(sticky_status), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU model. Status bits are {Carry, Overflow, Zero, Negative}.
    logic [8:0] alu_wide;
    logic [7:0] alu_r8;
    logic       alu_c;
    logic       alu_v;
    always_comb begin
        alu_wide   = 9'h000;
        alu_r8     = 8'h00;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_result = 16'h0000;
        alu_status = 4'h0;
        if (alu_enable) begin
            case (alu_opcode)
                OP_ADD: begin
                    alu_wide = {1'b0, alu_operand1} + {1'b0, alu_operand2};
                    alu_r8   = alu_wide[7:0];
                    alu_c    = alu_wide[8];
                    alu_v    = (alu_operand1[7] == alu_operand2[7]) && (alu_r8[7] != alu_operand1[7]);
                end
                OP_SUB: begin
                    alu_r8 = alu_operand1 - alu_operand2;
                    alu_c  = alu_operand1 < alu_operand2;
                    alu_v  = (alu_operand1[7] != alu_operand2[7]) && (alu_r8[7] != alu_operand1[7]);
                end
                OP_AND: alu_r8 = alu_operand1 & alu_operand2;
                OP_INC: begin
                    alu_r8 = alu_operand1 + 8'h01;
                    alu_c  = alu_operand1 == 8'hFF;
                    alu_v  = alu_operand1 == 8'h7F;
                end
                default: alu_r8 = 8'h00;
            endcase
            alu_result = {8'h00, alu_r8};
            alu_status = {alu_c, alu_v, alu_r8 == 8'h00, alu_r8[7]};
        end
    end

    // Hold reset for two cycles and return at a falling edge with all inputs idle.
    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_op1 = 8'h00; cmd_op2 = 8'h00;
        cmd_use_acc = 1'b0; cmd_wb = 1'b0; acc_clear = 1'b0; sticky_clear = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present a command and wait for its accept edge. Return at the falling
    // edge inside the EXEC cycle with cmd_valid dropped.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input logic wb);
        int n;
        cmd_opcode = op; cmd_op1 = a; cmd_op2 = b; cmd_use_acc = ua; cmd_wb = wb;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_op1 = 8'h00; cmd_op2 = 8'h00;
        cmd_use_acc = 1'b0; cmd_wb = 1'b0; acc_clear = 1'b0; sticky_clear = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_status, alu_enable} !== 22'h0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b result=%h status=%b en=%b, required all 0",
                     rsp_valid, rsp_result, rsp_status, alu_enable);
        end
        checks++;
        if ({alu_operand1, alu_operand2, alu_opcode} !== 20'h0) begin
            failures++;
            $display("FAIL reset_alu: got op1=%h op2=%h opc=%h, required 0",
                     alu_operand1, alu_operand2, alu_opcode);
        end
        checks++;
        if ({acc_value, sticky_status, op_count} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state: got acc=%h sticky=%b count=%0d, required 0",
                     acc_value, sticky_status, op_count);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        checks++;
        if ({alu_enable, rsp_valid, alu_operand1, alu_operand2, alu_opcode} !== {1'b1, 1'b0, 8'h7F, 8'h01, OP_ADD}) begin
            failures++;
            $display("FAIL add_exec: got en=%b rv=%b op1=%h op2=%h opc=%h, required 1 0 7f 01 4",
                     alu_enable, rsp_valid, alu_operand1, alu_operand2, alu_opcode);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_status, op_count} !== {1'b1, 16'h0080, 4'b0101, 8'd1}) begin
            failures++;
            $display("FAIL add_rsp: got rv=%b result=%h status=%b count=%0d, required 1 0080 0101 1",
                     rsp_valid, rsp_result, rsp_status, op_count);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, alu_enable, cmd_ready, alu_operand1} !== {1'b0, 1'b0, 1'b1, 8'h7F}) begin
            failures++;
            $display("FAIL add_idle: got rv=%b en=%b rdy=%b op1=%h, required 0 0 1 7f",
                     rsp_valid, alu_enable, cmd_ready, alu_operand1);
        end
    endtask

    task automatic test_acc_chain();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            issue(OP_INC, 8'hAA, 8'h00, 1'b1, 1'b1);
            @(negedge clk);
            checks++;
            if ({acc_value, rsp_result} !== {8'(i), 16'(i)}) begin
                failures++;
                $display("FAIL acc_chain_%0d: got acc=%h result=%h, required %h %h",
                         i, acc_value, rsp_result, 8'(i), 16'(i));
            end
        end
    endtask

    task automatic test_sticky();
        do_reset();
        issue(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({rsp_result, rsp_status, sticky_status} !== {16'h00FF, 4'b1001, 4'b1001}) begin
            failures++;
            $display("FAIL sticky_sub: got result=%h status=%b sticky=%b, required 00ff 1001 1001",
                     rsp_result, rsp_status, sticky_status);
        end
        issue(OP_AND, 8'h0F, 8'hF0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({rsp_status, sticky_status} !== {4'b0010, 4'b1011}) begin
            failures++;
            $display("FAIL sticky_and: got status=%b sticky=%b, required 0010 1011",
                     rsp_status, sticky_status);
        end
        // A clear during EXEC keeps only the status of that operation.
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        sticky_clear = 1'b1;
        @(negedge clk);
        sticky_clear = 1'b0;
        checks++;
        if (sticky_status !== 4'b0101) begin
            failures++;
            $display("FAIL sticky_clear_exec: got sticky=%b, required 0101", sticky_status);
        end
        // A clear outside EXEC empties the register.
        @(negedge clk);
        sticky_clear = 1'b1;
        @(negedge clk);
        sticky_clear = 1'b0;
        checks++;
        if (sticky_status !== 4'b0000) begin
            failures++;
            $display("FAIL sticky_clear_idle: got sticky=%b, required 0000", sticky_status);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b_op1 [3] = '{8'h01, 8'h10, 8'h40};
        logic [7:0]  b_op2 [3] = '{8'h02, 8'h20, 8'h40};
        logic [15:0] exp_res [4] = '{16'h0080, 16'h0003, 16'h0030, 16'h0080};
        logic [15:0] got_res [8];
        int          got_cyc [8];
        int          nr;
        int          idx;
        logic        will_acc;
        do_reset();
        rsp_ready = 1'b0;
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        // A second command waits while the response is stalled.
        cmd_opcode = OP_ADD; cmd_op1 = b_op1[0]; cmd_op2 = b_op2[0];
        cmd_use_acc = 1'b0; cmd_wb = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_result, rsp_status, cmd_ready, op_count, alu_operand1}
                    !== {1'b1, 16'h0080, 4'b0101, 1'b0, 8'd1, 8'h7F}) begin
                failures++;
                $display("FAIL stall_%0d: got rv=%b res=%h st=%b rdy=%b cnt=%0d op1=%h, required 1 0080 0101 0 1 7f",
                         i, rsp_valid, rsp_result, rsp_status, cmd_ready, op_count, alu_operand1);
            end
            @(negedge clk);
        end
        // Release backpressure and stream the three queued commands.
        rsp_ready = 1'b1;
        nr = 0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (idx < 3);
            if (idx < 3) begin
                cmd_op1 = b_op1[idx];
                cmd_op2 = b_op2[idx];
            end
            #1;
            if (rsp_valid && rsp_ready && nr < 8) begin
                got_res[nr] = rsp_result;
                got_cyc[nr] = c;
                nr++;
            end
            will_acc = cmd_valid && cmd_ready;
            @(negedge clk);
            if (will_acc) idx++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (nr !== 4 || op_count !== 8'd4) begin
            failures++;
            $display("FAIL stream_count: got responses=%0d op_count=%0d, required 4 4", nr, op_count);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < nr) begin
                checks++;
                if (got_res[i] !== exp_res[i]) begin
                    failures++;
                    $display("FAIL stream_res_%0d: got %h, required %h", i, got_res[i], exp_res[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_cyc[i] - got_cyc[i-1] !== 2) begin
                        failures++;
                        $display("FAIL stream_gap_%0d: got %0d cycles, required 2",
                                 i, got_cyc[i] - got_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_coincidence();
        do_reset();
        issue(OP_ADD, 8'h02, 8'h03, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (acc_value !== 8'h05) begin
            failures++;
            $display("FAIL coin_setup: got acc=%h, required 05", acc_value);
        end
        // acc_clear against an EXEC writeback of 0x06: the clear wins.
        issue(OP_INC, 8'h00, 8'h00, 1'b1, 1'b1);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        checks++;
        if ({acc_value, rsp_result} !== {8'h00, 16'h0006}) begin
            failures++;
            $display("FAIL coin_wb_clear: got acc=%h result=%h, required 00 0006",
                     acc_value, rsp_result);
        end
        issue(OP_ADD, 8'h02, 8'h03, 1'b0, 1'b1);
        @(negedge clk);
        // A use_acc accept coincident with acc_clear latches the pre-clear value.
        acc_clear = 1'b1;
        issue(OP_INC, 8'hEE, 8'h00, 1'b1, 1'b0);
        acc_clear = 1'b0;
        checks++;
        if ({alu_operand1, acc_value} !== {8'h05, 8'h00}) begin
            failures++;
            $display("FAIL coin_accept_clear: got op1=%h acc=%h, required 05 00",
                     alu_operand1, acc_value);
        end
        @(negedge clk);
        checks++;
        if ({rsp_result, acc_value} !== {16'h0006, 8'h00}) begin
            failures++;
            $display("FAIL coin_nowb: got result=%h acc=%h, required 0006 00", rsp_result, acc_value);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(OP_ADD, 8'h02, 8'h03, 1'b0, 1'b1);
        @(negedge clk);
        issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_enable, rsp_valid, rsp_result, alu_operand1, alu_operand2, alu_opcode, acc_value, op_count}
                !== 54'h0) begin
            failures++;
            $display("FAIL midreset_async: got en=%b rv=%b res=%h op1=%h op2=%h opc=%h acc=%h cnt=%0d, required all 0",
                     alu_enable, rsp_valid, rsp_result, alu_operand1, alu_operand2, alu_opcode, acc_value, op_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, cmd_ready, acc_value, op_count} !== {1'b0, 1'b1, 8'h00, 8'd0}) begin
                failures++;
                $display("FAIL midreset_after_%0d: got rv=%b rdy=%b acc=%h cnt=%0d, required 0 1 00 0",
                         i, rsp_valid, cmd_ready, acc_value, op_count);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add();
        test_acc_chain();
        test_sticky();
        test_back_to_back();
        test_coincidence();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequencer upstream of `alu_flags`. Accepts ALU commands over a valid/ready handshake and drives `alu_flags` operands, opcode and enable from registered fields.
- Captures the ALU result and the [Carry, Overflow, Zero, Negative] status into a registered response port with backpressure.
- Maintains an 8-bit accumulator for chained operations, a sticky status register and a completed-operation counter.
- Sits between the command source and the combinational ALU.

Parameters:
- ACC_INIT, 8'h00, accumulator value after reset and after acc_clear.
- COUNT_W, 8, width of op_count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_opcode  input  4  ALU opcode, passed through unmodified.
- cmd_op1  input  8  operand 1, ignored when cmd_use_acc=1.
- cmd_op2  input  8  operand 2.
- cmd_use_acc  input  1  use the accumulator as operand 1.
- cmd_wb  input  1  write result[7:0] back to the accumulator.
- acc_clear  input  1  synchronous accumulator reload to ACC_INIT.
- sticky_clear  input  1  synchronous clear of sticky_status.
- alu_operand1  output  8  to ALU oparand1.
- alu_operand2  output  8  to ALU oparand2.
- alu_opcode  output  4  to ALU opcode.
- alu_enable  output  1  to ALU enable.
- alu_result  input  16  from ALU result.
- alu_status  input  4  from ALU status.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  16  registered ALU result.
- rsp_status  output  4  registered ALU status.
- acc_value  output  8  current accumulator.
- sticky_status  output  4  OR of all captured statuses since the last clear.
- op_count  output  COUNT_W  completed EXEC count.

Behaviour:
- **Reset (rst=1, asynchronous):**
  - State goes to IDLE.
  - Latched op1/op2/opcode/wb cleared to 0; alu_* outputs therefore 0.
  - rsp_valid=0, rsp_result=0, rsp_status=0.
  - acc_value=ACC_INIT, sticky_status=0, op_count=0.
  - Any in-flight command is discarded with no response.
- **States:** IDLE, EXEC, RESP.
- **Accept rule:** cmd_ready = (state==IDLE) | (state==RESP & rsp_ready). A command is accepted on a clock edge where cmd_valid & cmd_ready.
- **On accept:**
  - Latch opcode, op2 and wb.
  - Latch op1 = cmd_use_acc ? acc_value : cmd_op1, where acc_value is the register value in that cycle (pre-clear if acc_clear is coincident).
  - Next state EXEC.
- **IDLE:** no accept -> stay in IDLE.
- **EXEC (exactly 1 cycle):**
  - alu_enable=1; ALU driven from the latched fields.
  - At the ending edge: rsp_result<=alu_result, rsp_status<=alu_status.
  - If wb, acc<=alu_result[7:0].
  - sticky_status <= (sticky_clear ? 0 : sticky_status) | alu_status, so the current op's status always survives a coincident clear.
  - op_count<=op_count+1, wrapping modulo 2^COUNT_W.
  - Next state RESP.
- **alu_enable** is 0 in IDLE and RESP. The alu_operand*/alu_opcode outputs hold their latched values at all times.
- **RESP:**
  - rsp_valid=1; rsp_result and rsp_status are held stable while rsp_ready=0.
  - rsp_ready=1 and accept -> EXEC.
  - rsp_ready=1 and no accept -> IDLE.
  - rsp_ready=0 -> stay in RESP; cmd_ready=0.
- **Latency:** accept at the edge ending cycle k; EXEC in cycle k+1; rsp_valid high in cycle k+2.
- **Throughput:** one command per 2 cycles with rsp_ready held high.
- **acc_clear:**
  - Outside the EXEC edge: acc<=ACC_INIT.
  - Coincident with an EXEC writeback: acc_clear wins and acc=ACC_INIT.
- **sticky_clear** outside EXEC: sticky_status<=0.
- **Opcodes:** no checking in this block. Unsupported opcodes pass through and capture whatever the ALU returns.
- **Widths:** accumulator writeback uses result[7:0] only. result[15:8] is reported but never stored in the accumulator.

Test Plan:
- Reset, then ADD: op1=8'h7F, op2=8'h01, opcode 4'b0100 -> rsp_valid 2 cycles after accept, rsp_result=16'h0080, rsp_status=4'b0101, op_count=1.
- Accumulator chain: ACC_INIT=0, 3x INC (4'b1101) with use_acc=1, wb=1 -> acc_value=1,2,3 after each EXEC; last rsp_result=16'h0003.
- Sticky status: SUB 0x00-0x01 (4'b0101) -> rsp_status=4'b1001; then AND 0x0F&0xF0 (4'b0110) -> rsp_status=4'b0010, sticky_status=4'b1011. Assert sticky_clear during the next EXEC -> sticky_status equals that op's status only.
- Backpressure/throughput:
  - rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, second command not accepted.
  - Then rsp_ready=1 with cmd_valid held -> responses every 2 cycles, no command lost or duplicated.
- Coincidence: acc=8'h05; acc_clear in the same cycle as an EXEC with wb and result 8'h06 -> acc_value=ACC_INIT. A use_acc accept coincident with acc_clear latches op1=8'h05.
- Reset mid-operation: rst asserted during EXEC -> outputs go to reset values immediately, no response issued. After release, cmd_ready=1 and acc_value=ACC_INIT.
